instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset and SHALL be word-aligned.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  read data valid this cycle.
- imem_data  in  32  instruction word from memory.
- instr  out  32  held instruction to decode; opcode is instr[31:26].
- instr_valid  out  1  instr is valid for the current pc.
- stall  in  1  downstream not ready; hold the current instruction.
- branch  in  2  decoded branch class from main control: 00 none, 01 unconditional, 10 conditional, 11 call.
- branch_cond  in  1  condition result for class 10.
- branch_target  in  32  target address for classes 01, 10 and 11.
- pc  out  32  address of the held instruction.
- pc_link  out  32  pc+4; register write value for a call.

Function
REQ-003 The block SHALL use three states: IDLE, FETCH and HOLD.
REQ-004 IDLE SHALL last exactly one cycle after reset deassertion, then go to FETCH.
REQ-005 In FETCH:
- imem_req SHALL be 1 and imem_addr SHALL equal pc.
- The state SHALL stay in FETCH until imem_ack=1.
- On the ack edge, instr SHALL capture imem_data, instr_valid SHALL go 1, and the state SHALL go to HOLD.
REQ-006 In HOLD:
- imem_req SHALL be 0.
- instr and pc SHALL stay stable while stall=1.
- imem_ack SHALL be ignored.
REQ-007 In HOLD with stall=0, the instruction SHALL retire on that edge:
- pc SHALL load next_pc.
- instr_valid SHALL clear.
- The state SHALL go to FETCH.
REQ-008 taken SHALL be (branch==01) or (branch==11) or (branch==10 and branch_cond==1).
REQ-009 next_pc SHALL be {branch_target[31:2],2'b00} when taken, otherwise pc+4.
REQ-010 The branch inputs SHALL be sampled only on the retire edge and ignored at all other times.
REQ-011 pc+4 SHALL be computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-012 pc_link SHALL always equal pc+4 (same wrap rule) and SHALL be combinational from pc.
REQ-013 Latency SHALL be one cycle from imem_ack to instr_valid=1, and one cycle from retire to imem_req=1 at the new pc.
REQ-014 When ack and memory are zero-wait, one instruction SHALL retire every 2 cycles.
REQ-015 The low two bits of pc SHALL always be 00.
REQ-016 imem_data SHALL be captured only in FETCH with imem_ack=1; an ack in IDLE or HOLD SHALL have no effect.
REQ-017 instr_valid SHALL be 1 exactly when the state is HOLD.

Reset
REQ-018 While rst=1, the block SHALL hold these values, applied asynchronously without waiting for clk:
- state IDLE, pc=RESET_PC
- instr=32'h0000_0000
- instr_valid=0, imem_req=0
REQ-019 Reset asserted during FETCH SHALL drop imem_req in the same cycle; a later imem_ack for the aborted request SHALL be ignored.
REQ-020 Reset asserted during HOLD SHALL discard the held instruction, so no retire occurs.
REQ-021 After rst deasserts, the first imem_req SHALL rise one cycle later, with imem_addr=RESET_PC.

Verification
REQ-022 Reset then zero-wait ack, stall=0, branch=00 -> imem_addr sequence 0,4,8,C; instr_valid pulses every second cycle.
REQ-023 Hold ack low 3 cycles, memory returns 32'h0400_1234 -> imem_req stays 1 for 4 cycles; instr=32'h0400_1234 one cycle after ack.
REQ-024 In HOLD at pc=8: stall=1 for 5 cycles, then stall=0 with branch=10, branch_cond=0 -> instr and pc are stable for 5 cycles; next fetch address is 32'hC.
REQ-025 At pc=10 in HOLD, branch=11, branch_target=32'h0000_0103 -> pc_link=32'h14; next fetch address is 32'h100.
REQ-026 RESET_PC=32'hFFFF_FFFC, branch=00 -> second fetch address is 32'h0000_0000.
REQ-027 Assert rst mid-FETCH, then pulse imem_ack during reset and one cycle after release -> instr stays 0; instr_valid stays 0; the first post-reset request is to RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with branch-redirected pc
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic [1:0]  branch,
    input  logic        branch_cond,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_link
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic        w_taken;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    assign w_taken    = (branch == 2'b01) || (branch == 2'b11) ||
                        ((branch == 2'b10) && branch_cond);
    assign w_pc_plus4 = r_pc + 32'd4;
    // Masking keeps pc word-aligned regardless of what decode hands us.
    assign w_target   = branch_target & 32'hFFFF_FFFC;
    assign w_next_pc  = w_taken ? w_target : w_pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= PC_INIT;
            r_instr <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Retire edge: the only time branch inputs are looked at.
                    if (!stall) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Derived from state so reset drops the request without waiting for clk.
    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_HOLD);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign pc_link     = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic [1:0]  branch;
    logic        branch_cond;
    logic [31:0] branch_target;

    logic        imem_req,    w_imem_req;
    logic [31:0] imem_addr,   w_imem_addr;
    logic [31:0] instr,       w_instr;
    logic        instr_valid, w_instr_valid;
    logic [31:0] pc,          w_pc;
    logic [31:0] pc_link,     w_pc_link;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch(branch), .branch_cond(branch_cond),
        .branch_target(branch_target),
        .pc(pc), .pc_link(pc_link)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(w_instr), .instr_valid(w_instr_valid),
        .stall(stall), .branch(branch), .branch_cond(branch_cond),
        .branch_target(branch_target),
        .pc(w_pc), .pc_link(w_pc_link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the DUT at a negedge in its first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; stall = 1'b0;
        branch = 2'b00; branch_cond = 1'b0; branch_target = 32'h0;
        step();
        step();
        check("rst_req",     {31'b0, imem_req},    32'h0);
        check("rst_valid",   {31'b0, instr_valid}, 32'h0);
        check("rst_pc",      pc,                   32'h0);
        check("rst_instr",   instr,                32'h0);
        check("rst_link",    pc_link,              32'h4);
        check("rst_wrap_pc", w_pc,                 32'hFFFF_FFFC);
        rst = 1'b0;
        check("idle_req",    {31'b0, imem_req},    32'h0);
        step();

        // Zero-wait streaming: 0,4,8,C with valid every other cycle
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("seq_req%0d", k),   {31'b0, imem_req},    32'h1);
            check($sformatf("seq_addr%0d", k),  imem_addr,            32'(4 * k));
            check($sformatf("seq_nv%0d", k),    {31'b0, instr_valid}, 32'h0);
            if (k == 0) check("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
            if (k == 1) check("wrap_addr1", w_imem_addr, 32'h0000_0000);
            imem_data = 32'h1000_0000 + 32'(k);
            step();
            check($sformatf("seq_v%0d", k),     {31'b0, instr_valid}, 32'h1);
            check($sformatf("seq_hreq%0d", k),  {31'b0, imem_req},    32'h0);
            check($sformatf("seq_instr%0d", k), instr,                32'h1000_0000 + 32'(k));
            step();
        end
        imem_ack = 1'b0;

        // Three wait cycles before ack
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wait_req%0d", k), {31'b0, imem_req},    32'h1);
            check($sformatf("wait_nv%0d", k),  {31'b0, instr_valid}, 32'h0);
            step();
        end
        check("wait_req3", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1; imem_data = 32'h0400_1234;
        step();
        imem_ack = 1'b0;
        check("wait_instr", instr,                32'h0400_1234);
        check("wait_valid", {31'b0, instr_valid}, 32'h1);

        // Stall in HOLD at pc=8, then not-taken conditional
        do_reset();
        imem_ack = 1'b1; imem_data = 32'h0;
        step(); step(); step(); step();
        check("st_pre_addr", imem_addr, 32'h8);
        imem_data = 32'hBEEF_0008; stall = 1'b1;
        step();
        imem_data = 32'h5555_AAAA;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("st_instr%0d", k), instr,                32'hBEEF_0008);
            check($sformatf("st_pc%0d", k),    pc,                   32'h8);
            check($sformatf("st_valid%0d", k), {31'b0, instr_valid}, 32'h1);
            check($sformatf("st_req%0d", k),   {31'b0, imem_req},    32'h0);
            step();
        end
        stall = 1'b0; branch = 2'b10; branch_cond = 1'b0; branch_target = 32'h40;
        step();
        branch = 2'b00;
        check("nt_addr", imem_addr,         32'hC);
        check("nt_req",  {31'b0, imem_req}, 32'h1);

        // Branch inputs outside the retire edge are ignored
        branch = 2'b01; branch_target = 32'h200;
        step();
        branch = 2'b00;
        step();
        check("ign_addr", imem_addr, 32'h10);

        // Call from pc=10
        step();
        check("call_pc",   pc,      32'h10);
        check("call_link", pc_link, 32'h14);
        branch = 2'b11; branch_target = 32'h0000_0103;
        step();
        branch = 2'b00;
        check("call_addr", imem_addr, 32'h100);

        // Taken conditional from pc=100
        step();
        branch = 2'b10; branch_cond = 1'b1; branch_target = 32'h0000_0207;
        step();
        branch = 2'b00; branch_cond = 1'b0;
        check("cond_addr", imem_addr, 32'h204);
        imem_ack = 1'b0;

        // Reset mid-FETCH with stray acks
        step();
        check("ab_pre_req", {31'b0, imem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check("ab_async_req",  {31'b0, imem_req}, 32'h0);
        check("ab_async_pc",   pc,                32'h0);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ab_rst_instr", instr,                32'h0);
        check("ab_rst_valid", {31'b0, instr_valid}, 32'h0);
        rst = 1'b0;
        step();
        imem_ack = 1'b0;
        check("ab_instr", instr,                32'h0);
        check("ab_valid", {31'b0, instr_valid}, 32'h0);
        check("ab_req",   {31'b0, imem_req},    32'h1);
        check("ab_addr",  imem_addr,            32'h0);
        step();
        check("ab_instr2", instr,                32'h0);
        check("ab_valid2", {31'b0, instr_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
